led_blinker: RTL and testbench
==============================

# led_blinker

Output-side indicator driver: turns a single-cycle request pulse (typically from the `button` debounce/sync/pulse chain or from control logic) into a visible LED pattern of N timed blinks with PWM dimming. Sits at the top level next to the input conditioning, driving board LEDs. It reports activity via `busy` and completion via a one-cycle `done` pulse.

## Interface
- `ON_CYCLES`, default 6_250_000: clock cycles per ON phase; must be ≥1.
- `OFF_CYCLES`, default 6_250_000: clock cycles per OFF phase; must be ≥1.
- `CNT_W`, default 4: width of the blink-count request.
- `PWM_W`, default 4: width of the brightness duty and PWM counter.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `trig`  in  1  single-cycle request strobe; `count` and `duty` are sampled when high.
- `count`  in  CNT_W  number of blinks requested; 0 = cancel.
- `duty`  in  PWM_W  brightness during ON phases; all-ones = fully on.
- `led`  out  1  LED drive.
- `busy`  out  1  high while a pattern is in progress.
- `done`  out  1  one-cycle pulse when a pattern completes normally.

## Operation
- Registers: state {IDLE, ON, OFF}, phase timer (width to hold max(ON_CYCLES, OFF_CYCLES)−1), remaining-blink counter (CNT_W), latched duty (PWM_W), free-running PWM counter (PWM_W), `done` flag.
- Reset: state IDLE, all counters 0, latched duty 0, `led`=0, `busy`=0, `done`=0.
- IDLE: `trig` with `count`≠0 → ON, remaining←count, duty latched, timer←0. `trig` with `count`=0 → ignored.
- ON: timer counts up; at timer=ON_CYCLES−1 → OFF, timer←0.
- OFF: timer counts up; at timer=OFF_CYCLES−1: if remaining=1 → IDLE and `done`=1 for one cycle; else remaining−1, → ON, timer←0.
- `trig` while busy (ON or OFF), `count`≠0: restart. → ON, remaining←count, duty re-latched, timer←0. No `done` for the aborted pattern.
- `trig` while busy, `count`=0: cancel. → IDLE next cycle, `led`=0, no `done`.
- `trig` on the same edge as a natural completion: `trig` wins. No `done`; behaves as restart or cancel.
- PWM counter increments every cycle, wrapping 2^PWM_W−1→0, independent of state.
- `led` = (state=ON) AND (latched duty = all-ones OR pwm_cnt < latched duty). It is decoded only from registers, with no combinational path from inputs. Duty 0 gives an ON phase with the LED dark; timing is unchanged.
- `busy` = (state≠IDLE).

## Timing
- `trig` sampled at edge k → state ON, `busy`=1 from cycle k+1; `led` can be high from cycle k+1.
- Each ON phase lasts exactly ON_CYCLES cycles and each OFF phase exactly OFF_CYCLES cycles.
- Total busy time for count N with no interruption: N·(ON_CYCLES+OFF_CYCLES) cycles.
- `done` is high in the first IDLE cycle after the last OFF phase, coincident with `busy` falling. It is registered and lasts exactly one cycle.
- A restart takes effect the cycle after `trig` and reloads the full ON phase.
- Reset mid-pattern clears outputs asynchronously. The first request after deassertion is honoured on the next edge.
- `count` = 2^CNT_W−1 (maximum) gives exactly that many blinks; no wrap.

## Test plan
(Bench parameters: ON_CYCLES=4, OFF_CYCLES=3, CNT_W=4, PWM_W=2.)
- Reset then `trig`, `count`=2, `duty`=3 → `led` high cycles 1–4 and 8–11, low 5–7 and 12–14. `busy` high cycles 1–14. `done`=1 only in cycle 15.
- `count`=1, `duty`=1 → during ON, `led` high only when pwm_cnt=0 (1 of every 4 cycles). Phase lengths unchanged; `done` at cycle 8.
- `count`=3 started; in the second OFF phase `trig` with `count`=1 → ON restarts next cycle for 4 cycles, OFF for 3, then a single `done`. No `done` from the aborted pattern.
- During ON, `trig` with `count`=0 → `busy`=0 and `led`=0 next cycle, no `done`. In IDLE, `trig` with `count`=0 → no change.
- `trig` asserted on the same edge as the final OFF expiry with `count`=1 → no `done`, new 7-cycle pattern follows.
- Assert `reset` asynchronously mid-ON → `led`, `busy`, `done` drop without a clock edge. After release, `count`=15 yields exactly 15 blinks (105 busy cycles).

Source files
------------

// File: rtl/led_blinker.sv
// Turns a single-cycle request into N timed blinks with PWM dimming during ON phases.
// Reports busy while a pattern runs and a one-cycle done pulse on normal completion.
module led_blinker #(
  parameter int ON_CYCLES  = 6_250_000,
  parameter int OFF_CYCLES = 6_250_000,
  parameter int CNT_W      = 4,
  parameter int PWM_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic [CNT_W-1:0] count,
  input  logic [PWM_W-1:0] duty,
  output logic             led,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PWM_W-1:0] PWM_ONE  = PWM_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [PWM_W-1:0]   duty_q, duty_d;
  logic [PWM_W-1:0]   pwm_q, pwm_d;
  logic               done_q, done_d;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    remain_d = remain_q;
    duty_d   = duty_q;
    pwm_d    = pwm_q + PWM_ONE;
    done_d   = 1'b0;

    // A request always wins, even over a natural completion on the same edge.
    if (trig && (count != '0)) begin
      state_d  = ON;
      remain_d = count;
      duty_d   = duty;
      timer_d  = '0;
    end else if (trig && (state_q != IDLE)) begin
      state_d  = IDLE;
      remain_d = '0;
      timer_d  = '0;
    end else begin
      case (state_q)
        IDLE: ;
        ON: begin
          if (timer_q == ON_LAST) begin
            state_d = OFF;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_ONE;
          end
        end
        OFF: begin
          if (timer_q == OFF_LAST) begin
            timer_d = '0;
            if (remain_q == CNT_ONE) begin
              state_d  = IDLE;
              remain_d = '0;
              done_d   = 1'b1;
            end else begin
              state_d  = ON;
              remain_d = remain_q - CNT_ONE;
            end
          end else begin
            timer_d = timer_q + TMR_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      remain_q <= '0;
      duty_q   <= '0;
      pwm_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      remain_q <= remain_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
      done_q   <= done_d;
    end
  end

  // Decoded purely from registers so there is no input-to-led path.
  assign led       = (state_q == ON) && ((&duty_q) || (pwm_q < duty_q));
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_led_blinker.sv
// Directed bench for led_blinker with ON=4, OFF=3, CNT_W=4, PWM_W=2.
module tb_led_blinker;

  logic       clk;
  logic       reset;
  logic       trig;
  logic [3:0] count;
  logic [1:0] duty;
  logic       led;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  int checks;
  int errors;
  logic [1:0] pwm_m;

  led_blinker #(
    .ON_CYCLES (4),
    .OFF_CYCLES(3),
    .CNT_W     (4),
    .PWM_W     (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .trig     (trig),
    .count    (count),
    .duty     (duty),
    .led      (led),
    .busy     (busy),
    .done     (done),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running brightness counter reference, cleared by reset.
  always @(posedge clk or posedge reset) begin
    if (reset) pwm_m <= 2'd0;
    else       pwm_m <= pwm_m + 2'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [3:0] c, input logic [1:0] d);
    trig  = 1'b1;
    count = c;
    duty  = d;
    tick();
    trig  = 1'b0;
  endtask

  // Walks an uninterrupted pattern starting in its first busy cycle.
  task automatic expect_pattern(input string tag, input int blinks, input bit use_pwm);
    int  total;
    int  p;
    bit  on_ph;
    bit  led_e;
    total = blinks * 7;
    for (int c = 1; c <= total + 1; c++) begin
      p     = (c - 1) % 7;
      on_ph = (c <= total) && (p < 4);
      led_e = on_ph && (!use_pwm || (pwm_m == 2'd0));
      chk($sformatf("%s_led_c%0d", tag, c), int'(led), int'(led_e));
      chk($sformatf("%s_busy_c%0d", tag, c), int'(busy), int'(c <= total));
      chk($sformatf("%s_done_c%0d", tag, c), int'(done), int'(c == total + 1));
      tick();
    end
  endtask

  initial begin
    int busy_cyc;
    int blinks;
    int dones;
    logic prev_led;

    checks = 0;
    errors = 0;
    trig   = 1'b0;
    count  = 4'd0;
    duty   = 2'd0;
    reset  = 1'b1;
    tick();
    tick();
    chk("rst_led", int'(led), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_state", int'(dbg_state), 0);
    reset = 1'b0;
    tick();

    // Two full-brightness blinks.
    start(4'd2, 2'd3);
    expect_pattern("p2", 2, 1'b0);

    // Single dim blink: lit only when the PWM counter is zero.
    start(4'd1, 2'd1);
    expect_pattern("dim", 1, 1'b1);

    // Restart from the second OFF phase of a three-blink pattern.
    start(4'd3, 2'd3);
    for (int c = 1; c <= 11; c++) begin
      chk($sformatf("rs_pre_done_c%0d", c), int'(done), 0);
      tick();
    end
    chk("rs_off_led", int'(led), 0);
    chk("rs_off_busy", int'(busy), 1);
    chk("rs_off_state", int'(dbg_state), 2);
    start(4'd1, 2'd3);
    expect_pattern("restart", 1, 1'b0);

    // Cancel during ON, then a zero-count request while idle.
    start(4'd2, 2'd3);
    tick();
    chk("cx_on_led", int'(led), 1);
    start(4'd0, 2'd0);
    chk("cx_busy", int'(busy), 0);
    chk("cx_led", int'(led), 0);
    chk("cx_done", int'(done), 0);
    tick();
    chk("cx_done_late", int'(done), 0);
    start(4'd0, 2'd3);
    chk("idle0_busy", int'(busy), 0);
    chk("idle0_led", int'(led), 0);
    chk("idle0_done", int'(done), 0);

    // Request on the same edge as the final OFF expiry.
    start(4'd1, 2'd3);
    for (int c = 1; c <= 6; c++) tick();
    chk("coll_last_off", int'(dbg_state), 2);
    start(4'd1, 2'd3);
    expect_pattern("collide", 1, 1'b0);

    // Asynchronous reset mid-ON, checked before any clock edge.
    start(4'd2, 2'd3);
    chk("ar_pre_led", int'(led), 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_led", int'(led), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_done", int'(done), 0);
    chk("ar_state", int'(dbg_state), 0);
    #1 reset = 1'b0;
    trig  = 1'b1;
    count = 4'd15;
    duty  = 2'd3;
    tick();
    trig  = 1'b0;

    busy_cyc = 0;
    blinks   = 0;
    dones    = 0;
    prev_led = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (busy) busy_cyc++;
      if (led && !prev_led) blinks++;
      prev_led = led;
      if (done) dones++;
      if (!busy) break;
      tick();
    end
    chk("max_busy_cycles", busy_cyc, 105);
    chk("max_blinks", blinks, 15);
    chk("max_done_count", dones, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
